branch_resolve: RTL and testbench

//  EX-stage branch resolution for the non-forwarding RV32I pipeline. Compares rs1/rs2 as two
//  16-bit halves through two compare_16bit instances, decides taken/not-taken per funct3,

---
 rtl/branch_resolve.sv | 190 +++++++++++++++++++
 tb/tb_branch_resolve.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// branch_resolve: EX-stage branch/JAL resolution for the non-forwarding RV32I
// pipeline. Operands are compared as two 16-bit halves, the taken decision and
// pc+imm target are registered, and a taken resolve raises a FLUSH_CYCLES-wide
// wrong-path flush toward IF/ID while ready_o holds EX off.
// Optional feature macro: BRANCH_STATS_EN (adds br_cnt_o / taken_cnt_o).

// Unsigned 16-bit magnitude compare used for each operand half.
module compare_16bit (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        eq,
    output logic        gt
);
    assign eq = (a == b);
    assign gt = (a > b);
endmodule

module branch_resolve #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic             br_en_i,
    input  logic             jmp_i,
    input  logic [2:0]       br_type_i,
    input  logic [31:0]      rs1_i,
    input  logic [31:0]      rs2_i,
    input  logic [31:0]      pc_i,
    input  logic [31:0]      imm_i,
    output logic             resolved_o,
    output logic             taken_o,
    output logic             redirect_o,
    output logic [31:0]      target_o,
    output logic             flush_o
`ifdef BRANCH_STATS_EN
    ,
    output logic [CNT_W-1:0] br_cnt_o,
    output logic [CNT_W-1:0] taken_cnt_o
`endif
);

    typedef enum logic {IDLE, FLUSH} state_t;

    state_t      state, state_nxt;
    logic [2:0]  cnt, cnt_nxt;

    logic        signed_cmp;
    logic        eq_lo, gt_lo, eq_hi, gt_hi;
    logic        eq, gt, lt;
    logic        br_taken;
    logic        accept, resolve, taken, take_redirect;
    logic [31:0] target_nxt;

    // Parameter legality is checked at elaboration so a bad override fails early.
    if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7) begin : g_flush_cycles_check
        $error("FLUSH_CYCLES must be in 1..7");
    end
    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    // Target wraps modulo 2^32; bit 0 is cleared as for JAL/branch targets.
    function automatic logic [31:0] calc_target(input logic [31:0] pc, input logic [31:0] imm);
        logic signed [31:0] sum;
        sum    = $signed(pc) + $signed(imm);
        sum[0] = 1'b0;
        return sum;
    endfunction

    // Signed compares (BLT/BGE, funct3 10x) flip the sign bit so an unsigned
    // compare of the upper half orders two's-complement values correctly.
    assign signed_cmp = (br_type_i[2:1] == 2'b10);

    compare_16bit u_cmp_lo (
        .a  (rs1_i[15:0]),
        .b  (rs2_i[15:0]),
        .eq (eq_lo),
        .gt (gt_lo)
    );

    compare_16bit u_cmp_hi (
        .a  ({rs1_i[31] ^ signed_cmp, rs1_i[30:16]}),
        .b  ({rs2_i[31] ^ signed_cmp, rs2_i[30:16]}),
        .eq (eq_hi),
        .gt (gt_hi)
    );

    assign eq = eq_hi & eq_lo;
    assign gt = gt_hi | (eq_hi & gt_lo);
    assign lt = ~eq & ~gt;

    // Taken decision per funct3; reserved encodings 010/011 never branch.
    always_comb begin
        br_taken = 1'b0;
        case (br_type_i)
            3'b000:  br_taken = eq;
            3'b001:  br_taken = ~eq;
            3'b100,
            3'b110:  br_taken = lt;
            3'b101,
            3'b111:  br_taken = ~lt;
            default: br_taken = 1'b0;
        endcase
    end

    assign ready_o       = (state == IDLE);
    assign accept        = valid_i & ready_o;
    assign resolve       = accept & (br_en_i | jmp_i);
    assign taken         = jmp_i | (br_en_i & br_taken);
    assign take_redirect = resolve & taken;
    assign target_nxt    = calc_target(pc_i, imm_i);

    // FSM state and flush countdown register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state <= IDLE;
            cnt   <= 3'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Next-state: a taken resolve enters FLUSH; FLUSH counts down to IDLE.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (take_redirect) begin
                    state_nxt = FLUSH;
                    cnt_nxt   = 3'(FLUSH_CYCLES - 1);
                end
            end
            FLUSH: begin
                if (cnt == 3'd0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - 3'd1;
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 3'd0;
            end
        endcase
    end

    // Registered results: pulses for one cycle, taken/target held until the next update.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            resolved_o <= 1'b0;
            taken_o    <= 1'b0;
            redirect_o <= 1'b0;
            target_o   <= 32'd0;
            flush_o    <= 1'b0;
        end else begin
            resolved_o <= resolve;
            redirect_o <= take_redirect;
            flush_o    <= take_redirect | ((state == FLUSH) && (cnt != 3'd0));
            if (resolve) begin
                taken_o <= taken;
            end
            if (take_redirect) begin
                target_o <= target_nxt;
            end
        end
    end

`ifdef BRANCH_STATS_EN
    // Statistics: accepted conditional branches (JAL excluded) and the taken subset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            br_cnt_o    <= '0;
            taken_cnt_o <= '0;
        end else if (resolve && !jmp_i) begin
            br_cnt_o <= br_cnt_o + 1'b1;
            if (br_taken) begin
                taken_cnt_o <= taken_cnt_o + 1'b1;
            end
        end
    end
`else
    // Statistics counters are not built in this configuration.
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: directed scenarios plus randomized
// traffic, all compared against a behavioural model of the resolve unit.
module tb_branch_resolve;
    localparam int FLUSH_CYCLES = 2;
    localparam int CNT_W        = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid, br_en, jmp;
    logic [2:0]  br_type;
    logic [31:0] rs1, rs2, pc, imm;
    logic        ready, resolved, taken, redirect, flush;
    logic [31:0] target;
`ifdef BRANCH_STATS_EN
    logic [CNT_W-1:0] br_cnt, taken_cnt;
`endif

    always #5 clk = ~clk;

    branch_resolve #(.FLUSH_CYCLES(FLUSH_CYCLES), .CNT_W(CNT_W)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .valid_i    (valid),
        .ready_o    (ready),
        .br_en_i    (br_en),
        .jmp_i      (jmp),
        .br_type_i  (br_type),
        .rs1_i      (rs1),
        .rs2_i      (rs2),
        .pc_i       (pc),
        .imm_i      (imm),
        .resolved_o (resolved),
        .taken_o    (taken),
        .redirect_o (redirect),
        .target_o   (target),
        .flush_o    (flush)
`ifdef BRANCH_STATS_EN
        ,
        .br_cnt_o   (br_cnt),
        .taken_cnt_o(taken_cnt)
`endif
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference model state: remaining flush cycles and the last reported results.
    int               m_rem;
    logic             m_resolved, m_taken, m_redirect;
    logic [31:0]      m_target;
    logic [CNT_W-1:0] m_brcnt, m_tkcnt;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Branch outcome from the ISA definition using native 32-bit compares.
    function automatic logic ref_taken(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_reset();
        m_rem = 0; m_resolved = 0; m_taken = 0; m_redirect = 0;
        m_target = 0; m_brcnt = 0; m_tkcnt = 0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".ready"},    32'(ready),    32'(m_rem == 0));
        chk({tag, ".resolved"}, 32'(resolved), 32'(m_resolved));
        chk({tag, ".taken"},    32'(taken),    32'(m_taken));
        chk({tag, ".redirect"}, 32'(redirect), 32'(m_redirect));
        chk({tag, ".flush"},    32'(flush),    32'(m_rem > 0));
        chk({tag, ".target"},   target,        m_target);
`ifdef BRANCH_STATS_EN
        chk({tag, ".br_cnt"},    32'(br_cnt),    32'(m_brcnt));
        chk({tag, ".taken_cnt"}, 32'(taken_cnt), 32'(m_tkcnt));
`endif
    endtask

    // One clock: the model consumes the inputs present at the edge, then outputs are compared.
    task automatic step(input string tag);
        logic tk;
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else if (m_rem > 0) begin
            m_rem--;
            m_resolved = 0;
            m_redirect = 0;
        end else begin
            m_resolved = 0;
            m_redirect = 0;
            if (valid && (jmp || br_en)) begin
                tk = jmp ? 1'b1 : ref_taken(br_type, rs1, rs2);
                m_resolved = 1;
                m_taken    = tk;
                if (!jmp) begin
                    m_brcnt++;
                    if (tk) m_tkcnt++;
                end
                if (tk) begin
                    m_redirect = 1;
                    m_target   = (pc + imm) & 32'hFFFF_FFFE;
                    m_rem      = FLUSH_CYCLES;
                end
            end
        end
        check_outputs(tag);
    endtask

    task automatic drive(input logic v, input logic b, input logic j, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] bb,
                         input logic [31:0] p, input logic [31:0] i);
        valid = v; br_en = b; jmp = j; br_type = f;
        rs1 = a; rs2 = bb; pc = p; imm = i;
    endtask

    task automatic idle(input string tag, input int n);
        for (int k = 0; k < n; k++) begin
            drive(0, 0, 0, 3'b000, 0, 0, 0, 0);
            step(tag);
        end
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 5))
            0: return 32'h8000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'hFFFF_FFFF;
            3: return 32'h0000_0000;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b;
        model_reset();
        rst = 1;
        drive(0, 0, 0, 3'b000, 0, 0, 0, 0);
        step("reset");
        rst = 0;
        step("after_reset");

        // Scenario 1: BEQ equal operands, flush lasts FLUSH_CYCLES.
        drive(1, 1, 0, 3'b000, 32'h1234_5678, 32'h1234_5678, 32'h100, 32'h20);
        step("beq_accept");
        chk("beq_target_const", target, 32'h0000_0120);
        chk("beq_redirect_const", 32'(redirect), 32'd1);
        idle("beq_flush", 3);

        // Scenario 2: signed vs unsigned less-than with the same operands.
        drive(1, 1, 0, 3'b100, 32'hFFFF_FFFF, 32'h1, 32'h200, 32'h40);
        step("blt_accept");
        idle("blt_flush", 2);
        drive(1, 1, 0, 3'b110, 32'hFFFF_FFFF, 32'h1, 32'h300, 32'h40);
        step("bltu_accept");
        chk("bltu_taken_const", 32'(taken), 32'd0);
        idle("bltu_after", 1);

        // Scenario 3: BGE decided by the upper half, then by the lower half, then funct3 010.
        drive(1, 1, 0, 3'b101, 32'h0001_0000, 32'h0000_FFFF, 32'h400, 32'h8);
        step("bge_hi");
        idle("bge_hi_flush", 2);
        drive(1, 1, 0, 3'b101, 32'h0001_FFFF, 32'h0001_FFFE, 32'h500, 32'h8);
        step("bge_lo");
        idle("bge_lo_flush", 2);
        drive(1, 1, 0, 3'b010, 32'h5, 32'h5, 32'h600, 32'h8);
        step("f010");
        chk("f010_taken_const", 32'(taken), 32'd0);

        // Scenario 4: JAL target wraps; a branch offered during the flush is ignored.
        drive(1, 0, 1, 3'b000, 0, 0, 32'hFFFF_FFF0, 32'h20);
        step("jal_wrap");
        chk("jal_target_const", target, 32'h0000_0010);
        drive(1, 1, 0, 3'b000, 32'h7, 32'h7, 32'h1000, 32'h100);
        step("flush_ignore");
        chk("flush_ignore_target", target, 32'h0000_0010);
        idle("jal_after", 2);

        // Back-to-back: a second taken branch in the first ready cycle restarts the flush.
        drive(1, 1, 0, 3'b001, 32'h1, 32'h2, 32'h700, 32'h10);
        step("b2b_first");
        idle("b2b_mid", 1);
        drive(1, 1, 0, 3'b001, 32'h3, 32'h4, 32'h800, 32'h10);
        step("b2b_wait");
        drive(1, 1, 0, 3'b001, 32'h3, 32'h4, 32'h800, 32'h10);
        step("b2b_second");
        idle("b2b_after", 3);

        // Scenario 5: reset during the second flush cycle.
        drive(1, 1, 0, 3'b001, 32'h10, 32'h20, 32'h900, 32'h40);
        step("rst_accept");
        idle("rst_flush1", 1);
        rst = 1;
        step("rst_mid_flush");
        chk("rst_ready_const", 32'(ready), 32'd1);
        chk("rst_flush_const", 32'(flush), 32'd0);
        rst = 0;
        idle("rst_after", 1);

        // Scenario 6: counter tallies over 5 branches (3 taken) and 2 JALs.
        rst = 1;
        step("cnt_reset");
        rst = 0;
        drive(1, 1, 0, 3'b000, 32'h1, 32'h1, 32'h0, 32'h10); step("c_beq_t");  idle("c", 2);
        drive(1, 1, 0, 3'b000, 32'h1, 32'h2, 32'h0, 32'h10); step("c_beq_n");
        drive(1, 0, 1, 3'b000, 32'h0, 32'h0, 32'h0, 32'h40); step("c_jal1");   idle("c", 2);
        drive(1, 1, 0, 3'b110, 32'h1, 32'h2, 32'h0, 32'h10); step("c_bltu_t"); idle("c", 2);
        drive(1, 1, 0, 3'b111, 32'h1, 32'h2, 32'h0, 32'h10); step("c_bgeu_n");
        drive(1, 0, 1, 3'b000, 32'h0, 32'h0, 32'h0, 32'h80); step("c_jal2");   idle("c", 2);
        drive(1, 1, 0, 3'b001, 32'h1, 32'h2, 32'h0, 32'h10); step("c_bne_t");  idle("c", 2);
`ifdef BRANCH_STATS_EN
        chk("br_cnt_const", 32'(br_cnt), 32'd5);
        chk("taken_cnt_const", 32'(taken_cnt), 32'd3);
`endif

        // Randomized traffic with biased operands and occasional reset.
        for (int n = 0; n < 500; n++) begin
            a = pick_operand();
            case ($urandom_range(0, 3))
                0: b = a;
                1: b = {a[31:16], 16'($urandom)};
                2: b = pick_operand();
                default: b = $urandom;
            endcase
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                  3'($urandom), a, b, $urandom, $urandom);
            rst = ($urandom_range(0, 59) == 0);
            step("rand");
        end
        rst = 0;
        idle("final", 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
